// File: rtl/softmax_pkg.sv
// softmax_pkg
// Shared types and defaults for the streaming argmax classifier stage.
//   state_e            : FSM encoding for the frame collector
//   SOFTMAX_WORD_SIZE  : default score width (matches the FC layer output)
//   SOFTMAX_LAYER_SIZE : default number of scores per frame
//   idx_w()            : class index width for a given layer size
package softmax_pkg;

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_DONE    = 1'b1
   } state_e;

   localparam int SOFTMAX_WORD_SIZE  = 16;
   localparam int SOFTMAX_LAYER_SIZE = 10;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp
// Combinational running-max update for one candidate score.
//   cur_max  / cur_idx  : running maximum and its index
//   cand     / cand_idx : incoming score and its beat index
//   first               : candidate is beat 0, loads unconditionally
//   nxt_max  / nxt_idx  : updated running maximum and index
// Strict signed greater-than, so on a tie the earlier (lower) index is kept.
module argmax_cmp
   import softmax_pkg::*;
#(
   parameter int WORD_SIZE = SOFTMAX_WORD_SIZE,
   parameter int IDX_W     = idx_w(SOFTMAX_LAYER_SIZE)
)(
   input  logic signed [WORD_SIZE-1:0] cur_max,
   input  logic        [IDX_W-1:0]     cur_idx,
   input  logic signed [WORD_SIZE-1:0] cand,
   input  logic        [IDX_W-1:0]     cand_idx,
   input  logic                        first,
   output logic signed [WORD_SIZE-1:0] nxt_max,
   output logic        [IDX_W-1:0]     nxt_idx
);

   logic take;

   assign take    = first || (cand > cur_max);
   assign nxt_max = take ? cand     : cur_max;
   assign nxt_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/softmax_stream_argmax.sv
// softmax_stream_argmax
// Sequential argmax over a frame of LAYER_SIZE signed scores arriving one
// per beat on a valid/ready stream; returns the winning class index on a
// second valid/ready interface.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : score beat handshake
//   in_data             : signed score, neuron order 0..LAYER_SIZE-1
//   in_last             : producer's end-of-frame marker (checked, not trusted)
//   out_valid/out_ready : result handshake
//   out_class           : argmax index
//   out_err             : frame length mismatch, qualified by out_valid
//   out_max             : winning score, only when SOFTMAX_MAXVAL_EN is defined
//
// State table
//   state     | meaning
//   S_COLLECT | accepting beats, folding each into the running max
//   S_DONE    | result held on the outputs until out_ready
module softmax_stream_argmax
   import softmax_pkg::*;
#(
   parameter  int WORD_SIZE  = SOFTMAX_WORD_SIZE,
   parameter  int LAYER_SIZE = SOFTMAX_LAYER_SIZE,
   localparam int IDX_W      = idx_w(LAYER_SIZE)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WORD_SIZE-1:0] in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic        [IDX_W-1:0]     out_class,
   output logic                        out_err
`ifdef SOFTMAX_MAXVAL_EN
   ,
   output logic signed [WORD_SIZE-1:0] out_max
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_SIZE - 1);

   state_e                      state_q;
   logic        [IDX_W-1:0]     cnt_q;
   logic signed [WORD_SIZE-1:0] max_q;
   logic signed [WORD_SIZE-1:0] max_d;
   logic        [IDX_W-1:0]     idx_q;
   logic        [IDX_W-1:0]     idx_d;
   logic                        err_q;
   logic                        in_ready_q;
   logic                        out_valid_q;
   logic                        last_beat;
   logic                        beat_err;

   assign last_beat = (cnt_q == LAST_IDX);
   // in_last must agree with the counter on every beat, not just the final one.
   assign beat_err  = in_last != last_beat;

   argmax_cmp #(
      .WORD_SIZE (WORD_SIZE),
      .IDX_W     (IDX_W)
   ) u_cmp (
      .cur_max  (max_q),
      .cur_idx  (idx_q),
      .cand     (in_data),
      .cand_idx (cnt_q),
      .first    (cnt_q == '0),
      .nxt_max  (max_d),
      .nxt_idx  (idx_d)
   );

   // in_ready_q is always 1 in S_COLLECT, so a beat is simply in_valid there.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_COLLECT;
         cnt_q       <= '0;
         max_q       <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (in_valid) begin
                  max_q <= max_d;
                  idx_q <= idx_d;
                  err_q <= err_q | beat_err;
                  // The counter alone decides where the frame closes.
                  if (last_beat) begin
                     cnt_q       <= '0;
                     state_q     <= S_DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_COLLECT;
                  err_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_COLLECT;
         endcase
      end
   end

   // idx_q/max_q double as the result registers: nothing loads them in
   // S_DONE, and the next frame's beat 0 overwrites them unconditionally.
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_class = idx_q;
   assign out_err   = err_q;

`ifdef SOFTMAX_MAXVAL_EN
   assign out_max = max_q;
`else
   // max_q still drives the comparator; it is just not exported.
`endif

endmodule

// File: tb/tb_softmax_stream_argmax.sv
// tb_softmax_stream_argmax
// Table-driven frames plus hand-written corner sequences and random frames.
// Expected results are queued as each frame is driven and compared against
// every cycle the DUT presents a result; popped on the result handshake.
// Build with SOFTMAX_MAXVAL_EN to also check out_max.
module tb_softmax_stream_argmax;

   localparam int W = 16;
   localparam int L = 10;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] in_data = '0;
   logic                in_last = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [3:0]          out_class;
   logic                out_err;
`ifdef SOFTMAX_MAXVAL_EN
   logic signed [W-1:0] out_max;
`endif

   always #5 clk = ~clk;

   softmax_stream_argmax #(.WORD_SIZE(W), .LAYER_SIZE(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_err   (out_err)
`ifdef SOFTMAX_MAXVAL_EN
      ,
      .out_max   (out_max)
`endif
   );

   typedef int arr_t [L];

   typedef struct {
      arr_t s;
      int   last_pos;
      int   cls;
      int   err;
      int   mx;
   } vec_t;

   typedef struct {
      int cls;
      int err;
      int mx;
   } exp_t;

   vec_t tv [6];
   exp_t sbq [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, $signed(got), $signed(expv), $time);
      end
   endtask

   task automatic set_vec(input int k, input arr_t s, input int lp, input int cls,
                          input int err, input int mx);
      tv[k].s        = s;
      tv[k].last_pos = lp;
      tv[k].cls      = cls;
      tv[k].err      = err;
      tv[k].mx       = mx;
   endtask

   function automatic exp_t model(input arr_t s, input int lp);
      exp_t e;
      e.mx  = s[0];
      e.cls = 0;
      for (int i = 1; i < L; i++) begin
         if (s[i] > e.mx) begin
            e.mx  = s[i];
            e.cls = i;
         end
      end
      e.err = (lp != L - 1) ? 1 : 0;
      return e;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
   task automatic drive_beat(input int d, input bit last);
      bit ok;
      int n;
      logic [31:0] dv;
      dv       = d;
      in_valid = 1'b1;
      in_data  = dv[W-1:0];
      in_last  = last;
      n        = 0;
      ok       = 1'b0;
      do begin
         @(negedge clk);
         ok = (in_ready === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("beat_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic send_frame(input arr_t s, input int lp, input exp_t e, input bit gap);
      sbq.push_back(e);
      for (int i = 0; i < L; i++) begin
         if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         if (i == L - 1) check("valid_early", {31'd0, out_valid}, 32'd0);
         drive_beat(s[i], i == lp);
      end
      check("valid_latency", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", sbq.size(), 32'd0);
   endtask

   task automatic check_reset_vals();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_class", {28'd0, out_class}, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
`ifdef SOFTMAX_MAXVAL_EN
      check("rst_out_max", 32'($signed(out_max)), 32'd0);
`endif
   endtask

   // Result monitor: while a result is presented, it must match the front
   // of the queue every cycle (covers stability under back-pressure).
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got class %0d, required no result pending", out_class);
            end else begin
               check("out_class", {28'd0, out_class}, sbq[0].cls);
               check("out_err", {31'd0, out_err}, sbq[0].err);
`ifdef SOFTMAX_MAXVAL_EN
               check("out_max", 32'($signed(out_max)), sbq[0].mx);
`endif
               check("in_ready_done", {31'd0, in_ready}, 32'd0);
               if (out_ready) void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      exp_t e;
      arr_t s;
      arr_t rs;
      int   lp;
      int   mode;
      bit   gap;
      logic [15:0] r;

      set_vec(0, '{5, -3, 7, 7, 0, 1, 2, -8, 6, 4}, 9, 2, 0, 7);
      set_vec(1, '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767},
              9, 9, 0, -32767);
      set_vec(2, '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100}, 9, 0, 0, 100);
      set_vec(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 6, 9, 1, 10);
      set_vec(4, '{-5, -4, -9, -1, -7, -3, -2, -6, -8, -10}, 9, 3, 0, -1);
      set_vec(5, '{32767, 0, -1, 5, 9, 32767, 3, 2, 1, 32767}, 9, 0, 0, 32767);

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals();

      // Table frames, back to back with out_ready held high.
      for (int i = 0; i < 6; i++) begin
         e.cls = tv[i].cls;
         e.err = tv[i].err;
         e.mx  = tv[i].mx;
         send_frame(tv[i].s, tv[i].last_pos, e, 1'b0);
      end
      drain();

      // in_valid toggling, result held for 5 cycles by out_ready low.
      out_ready = 1'b0;
      e.cls = tv[0].cls;
      e.err = tv[0].err;
      e.mx  = tv[0].mx;
      send_frame(tv[0].s, tv[0].last_pos, e, 1'b1);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("in_ready_hold", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      e.cls = tv[4].cls;
      e.err = tv[4].err;
      e.mx  = tv[4].mx;
      send_frame(tv[4].s, tv[4].last_pos, e, 1'b0);
      drain();

      // Reset after beat 4 of a frame that would otherwise win on class 0.
      for (int i = 0; i < 5; i++) drive_beat(9, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals();
      s = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      e.cls = 3;
      e.err = 0;
      e.mx  = 1;
      send_frame(s, 9, e, 1'b0);
      drain();

      // Random frames against the reference model.
      for (int f = 0; f < 1000; f++) begin
         mode = $urandom_range(0, 3);
         for (int i = 0; i < L; i++) begin
            if (mode == 0) begin
               rs[i] = $urandom_range(0, 6) - 3;
            end else begin
               r     = 16'($urandom);
               rs[i] = int'($signed(r));
            end
         end
         lp  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : 9;
         gap = ($urandom_range(0, 7) == 0);
         send_frame(rs, lp, model(rs, lp), gap);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
